alu16_seq: RTL

Sequencing controller that executes 16-bit operations on the team's 8-bit combinational ALU. It accepts a 16-bit command over a valid/ready handshake and drives the ALU's operand, carry and opcode inputs for two cycles: low byte, then high byte, with carry chained between them. It captures the ALU's result, carry and zero outputs and returns a 16-bit result with flags over a second valid/ready handshake. It sits between the register file/control FSM and the ALU instance.

---
 rtl/alu16_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu16_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu16_seq
// Purpose  : Runs 16-bit operations on an external 8-bit combinational ALU.
//            A command is taken over cmd_valid/cmd_ready, and the ALU is then
//            driven for two cycles: low byte first, then high byte, with the
//            low-byte carry fed into the high byte. The result and flags are
//            returned over rsp_valid/rsp_ready. Only one command is in flight
//            at a time.
// Ports    : clk, rst (async, active-high)
//            cmd_valid/cmd_ready, cmd_a[15:0], cmd_b[15:0], cmd_op[3:0],
//            cmd_cin (only when ALU16_SEQ_CARRYIN_EN is defined)
//            alu_a[7:0], alu_b[7:0], alu_carry, alu_op[3:0]  -> ALU
//            alu_c[7:0], alu_carry_out, alu_zero             <- ALU
//            rsp_valid/rsp_ready, rsp_result[15:0], rsp_carry, rsp_zero
// Config   : ALU16_SEQ_CARRYIN_EN - adds cmd_cin, registered on accept and
//            used as the low-byte carry. Undefined: low-byte carry is 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [3:0]  cmd_op,
`ifdef ALU16_SEQ_CARRYIN_EN
    input  logic        cmd_cin,
`endif
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_carry,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_c,
    input  logic        alu_carry_out,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [3:0]  r_op;
    logic [7:0]  r_res_lo;
    logic [7:0]  r_res_hi;
    logic        r_c_lo;
    logic        r_c_hi;
    logic        r_z_lo;
    logic        r_z_hi;

    logic        w_accept;
    logic        w_is_arith;
    logic        w_cin_lo;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_is_arith = (r_op[3:2] == 2'b00);

`ifdef ALU16_SEQ_CARRYIN_EN
    logic r_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cin <= 1'b0;
        end else if (w_accept) begin
            r_cin <= cmd_cin;
        end
    end

    assign w_cin_lo = r_cin;
`else
    assign w_cin_lo = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register and next-state decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next_state = S_LO;
            S_LO:    w_next_state = S_HI;
            S_HI:    w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command capture and per-slice ALU result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= 16'd0;
            r_b      <= 16'd0;
            r_op     <= 4'd0;
            r_res_lo <= 8'd0;
            r_res_hi <= 8'd0;
            r_c_lo   <= 1'b0;
            r_c_hi   <= 1'b0;
            r_z_lo   <= 1'b0;
            r_z_hi   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= cmd_a;
                r_b  <= cmd_b;
                r_op <= cmd_op;
            end
            if (r_state == S_LO) begin
                r_res_lo <= alu_c;
                r_c_lo   <= alu_carry_out;
                r_z_lo   <= alu_zero;
            end
            if (r_state == S_HI) begin
                r_res_hi <= alu_c;
                r_c_hi   <= alu_carry_out;
                r_z_hi   <= alu_zero;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and registers only, so the ALU never
    // sees a combinational path from the command inputs.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready  = 1'b0;
        alu_a      = 8'd0;
        alu_b      = 8'd0;
        alu_carry  = 1'b0;
        alu_op     = 4'd0;
        rsp_valid  = 1'b0;
        rsp_result = 16'd0;
        rsp_carry  = 1'b0;
        rsp_zero   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_LO: begin
                alu_a     = r_a[7:0];
                alu_b     = r_b[7:0];
                alu_op    = r_op;
                alu_carry = w_cin_lo;
            end
            S_HI: begin
                alu_a = r_a[15:8];
                alu_b = r_b[15:8];
                // High slice of add/sub always consumes the low-slice carry,
                // so add becomes adc and sub becomes sbc.
                if (w_is_arith) begin
                    alu_op    = {r_op[3:1], 1'b1};
                    alu_carry = r_c_lo;
                end else begin
                    alu_op    = r_op;
                    alu_carry = 1'b0;
                end
            end
            S_RESP: begin
                rsp_valid  = 1'b1;
                rsp_result = {r_res_hi, r_res_lo};
                rsp_carry  = r_c_hi;
                rsp_zero   = r_z_lo & r_z_hi;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
